// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the backing-memory refill arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR    = 2'd1,
      RD_DC = 2'd2,
      RD_IC = 2'd3
   } arb_state_t;

   localparam int unsigned WORD_BYTES = 4;

   // Clears the byte-offset-within-line bits of a miss address.
   function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_bits);
      logic [63:0] mask;
      mask = ~((64'd1 << off_bits) - 64'd1);
      return addr & mask;
   endfunction

endpackage

// File: rtl/mem_refill_arbiter.sv
// Arbitrates the single-word memory port between D-cache stores, D refills and I refills,
// sequencing multi-beat line refills and raising the pipeline stall.
module mem_refill_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ic_miss,
   input  logic [ADDR_W-1:0]             ic_addr,
   input  logic                          dc_miss,
   input  logic [ADDR_W-1:0]             dc_addr,
   input  logic                          dc_wr_req,
   input  logic [ADDR_W-1:0]             dc_wr_addr,
   input  logic [31:0]                   dc_wr_data,
   output logic                          ic_fill_valid,
   output logic                          dc_fill_valid,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
   output logic [31:0]                   fill_data,
   output logic                          ic_done,
   output logic                          dc_done,
   output logic                          dc_wr_ack,
   output logic                          cache_miss,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [31:0]                   mem_wdata,
   input  logic                          mem_ack,
   input  logic [31:0]                   mem_rdata
);

   localparam int unsigned       CNT_W    = $clog2(LINE_WORDS);
   localparam int unsigned       OFF_BITS = $clog2(LINE_WORDS * WORD_BYTES);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(LINE_WORDS - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_BYTES);

   arb_state_t          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;

   logic                ack_s;
   logic                rd_ack_s;
   logic                last_s;
   logic [ADDR_W-1:0]   dc_base_s;
   logic [ADDR_W-1:0]   ic_base_s;

   // An ack only counts against an outstanding request, and never while reset aborts the transfer.
   assign ack_s     = mem_ack & mem_req_q & ~rst;
   assign rd_ack_s  = ack_s & ((state_q == RD_DC) | (state_q == RD_IC));
   assign last_s    = (cnt_q == LAST_IDX);
   assign dc_base_s = ADDR_W'(line_base(64'(dc_addr), OFF_BITS));
   assign ic_base_s = ADDR_W'(line_base(64'(ic_addr), OFF_BITS));

   // Arbitration FSM with registered memory-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= {CNT_W{1'b0}};
               if (dc_wr_req) begin
                  state_q     <= WR;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= dc_wr_addr;
                  mem_wdata_q <= dc_wr_data;
               end else if (dc_miss) begin
                  state_q    <= RD_DC;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= dc_base_s;
               end else if (ic_miss) begin
                  state_q    <= RD_IC;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= ic_base_s;
               end else begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
               end
            end
            WR: begin
               if (ack_s) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end
            end
            RD_DC, RD_IC: begin
               if (ack_s) begin
                  if (last_s) begin
                     state_q   <= IDLE;
                     mem_req_q <= 1'b0;
                     cnt_q     <= {CNT_W{1'b0}};
                  end else begin
                     cnt_q      <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                     mem_addr_q <= mem_addr_q + STEP;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;

   assign dc_wr_ack     = ack_s & (state_q == WR);
   assign dc_fill_valid = rd_ack_s & (state_q == RD_DC);
   assign ic_fill_valid = rd_ack_s & (state_q == RD_IC);
   assign dc_done       = dc_fill_valid & last_s;
   assign ic_done       = ic_fill_valid & last_s;
   assign fill_idx      = rd_ack_s ? cnt_q : {CNT_W{1'b0}};
   assign fill_data     = rd_ack_s ? mem_rdata : 32'd0;

   assign cache_miss    = rst ? 1'b0 : (ic_miss | dc_miss | dc_wr_req | (state_q != IDLE));

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed self-checking bench for mem_refill_arbiter with a 4-word line.
module tb_mem_refill_arbiter;

   localparam int unsigned LW      = 4;
   localparam logic [31:0] MEM_KEY = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ic_miss = 1'b0, dc_miss = 1'b0, dc_wr_req = 1'b0;
   logic [31:0] ic_addr = 32'd0, dc_addr = 32'd0, dc_wr_addr = 32'd0, dc_wr_data = 32'd0;
   logic        ic_fill_valid, dc_fill_valid, ic_done, dc_done, dc_wr_ack, cache_miss;
   logic [1:0]  fill_idx;
   logic [31:0] fill_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Memory model: read data is a keyed function of the word address.
   assign mem_rdata = mem_addr ^ MEM_KEY;

   mem_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .ic_miss(ic_miss), .ic_addr(ic_addr),
      .dc_miss(dc_miss), .dc_addr(dc_addr),
      .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
      .ic_fill_valid(ic_fill_valid), .dc_fill_valid(dc_fill_valid),
      .fill_idx(fill_idx), .fill_data(fill_data),
      .ic_done(ic_done), .dc_done(dc_done), .dc_wr_ack(dc_wr_ack),
      .cache_miss(cache_miss),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic exp_cm);
      check_eq({tag, "_req"},   32'(mem_req), 32'd0);
      check_eq({tag, "_icfv"},  32'(ic_fill_valid), 32'd0);
      check_eq({tag, "_dcfv"},  32'(dc_fill_valid), 32'd0);
      check_eq({tag, "_done"},  32'({ic_done, dc_done, dc_wr_ack}), 32'd0);
      check_eq({tag, "_idx"},   32'(fill_idx), 32'd0);
      check_eq({tag, "_data"},  fill_data, 32'd0);
      check_eq({tag, "_cm"},    32'(cache_miss), 32'(exp_cm));
   endtask

   // Expects LW back-to-back beats with mem_ack held high.
   task automatic do_refill(input string tag, input bit is_ic, input logic [31:0] base);
      logic [31:0] a;
      for (int b = 0; b < LW; b++) begin
         step();
         #1;
         a = base + 32'(4 * b);
         check_eq({tag, "_req"},  32'(mem_req), 32'd1);
         check_eq({tag, "_we"},   32'(mem_we), 32'd0);
         check_eq({tag, "_addr"}, mem_addr, a);
         check_eq({tag, "_icfv"}, 32'(ic_fill_valid), 32'(is_ic));
         check_eq({tag, "_dcfv"}, 32'(dc_fill_valid), 32'(!is_ic));
         check_eq({tag, "_idx"},  32'(fill_idx), 32'(b));
         check_eq({tag, "_data"}, fill_data, a ^ MEM_KEY);
         check_eq({tag, "_icd"},  32'(ic_done), 32'(is_ic && (b == LW - 1)));
         check_eq({tag, "_dcd"},  32'(dc_done), 32'(!is_ic && (b == LW - 1)));
         check_eq({tag, "_cm"},   32'(cache_miss), 32'd1);
      end
   endtask

   initial begin
      int beat;
      int pulses;

      // Reset: stall is forced low even with a pending miss.
      ic_miss = 1'b1;
      step(); #1;
      check_eq("rst_cm",    32'(cache_miss), 32'd0);
      check_eq("rst_req",   32'(mem_req), 32'd0);
      check_eq("rst_we",    32'(mem_we), 32'd0);
      check_eq("rst_addr",  mem_addr, 32'd0);
      check_eq("rst_wdata", mem_wdata, 32'd0);
      step();
      rst = 1'b0; ic_miss = 1'b0;
      #1;
      check_idle("post_rst", 1'b0);

      // I-side refill with mem_ack tied high.
      step();
      ic_miss = 1'b1; ic_addr = 32'h0000_1034; mem_ack = 1'b1;
      #1;
      check_eq("ic1_c0_cm",  32'(cache_miss), 32'd1);
      check_eq("ic1_c0_req", 32'(mem_req), 32'd0);
      do_refill("ic1", 1'b1, 32'h0000_1030);
      step(); ic_miss = 1'b0; #1;
      check_idle("ic1_end", 1'b0);

      // Store wins over a simultaneous I miss.
      step();
      dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_0200; dc_wr_data = 32'hDEAD_BEEF;
      ic_miss = 1'b1; ic_addr = 32'h0000_0100;
      #1;
      step(); #1;
      check_eq("st_req",   32'(mem_req), 32'd1);
      check_eq("st_we",    32'(mem_we), 32'd1);
      check_eq("st_addr",  mem_addr, 32'h0000_0200);
      check_eq("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_eq("st_ack",   32'(dc_wr_ack), 32'd1);
      check_eq("st_icfv",  32'(ic_fill_valid), 32'd0);
      step(); dc_wr_req = 1'b0; #1;
      check_idle("st_gap", 1'b1);
      do_refill("st_ic", 1'b1, 32'h0000_0100);
      step(); ic_miss = 1'b0; #1;
      check_idle("st_end", 1'b0);

      // D refill with memory wait states: ack every third cycle.
      step();
      dc_miss = 1'b1; dc_addr = 32'h0000_0040; mem_ack = 1'b0;
      #1;
      beat = 0;
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         mem_ack = (c % 3 == 0);
         #1;
         check_eq("ws_req",  32'(mem_req), 32'd1);
         check_eq("ws_addr", mem_addr, 32'h0000_0040 + 32'(4 * beat));
         check_eq("ws_dcfv", 32'(dc_fill_valid), 32'(mem_ack));
         check_eq("ws_dcd",  32'(dc_done), 32'(mem_ack && (beat == LW - 1)));
         if (mem_ack) begin
            check_eq("ws_idx", 32'(fill_idx), 32'(beat));
            beat++;
         end else begin
            check_eq("ws_idx0", 32'(fill_idx), 32'd0);
         end
         if (dc_fill_valid) pulses++;
      end
      check_eq("ws_pulses", 32'(pulses), 32'd4);
      step(); dc_miss = 1'b0; mem_ack = 1'b1; #1;
      check_idle("ws_end", 1'b0);

      // Simultaneous misses: D first, one IDLE cycle, then I; stall never drops.
      step();
      dc_miss = 1'b1; dc_addr = 32'h0000_0088;
      ic_miss = 1'b1; ic_addr = 32'h0000_01C4;
      #1;
      check_eq("sim_c0_cm", 32'(cache_miss), 32'd1);
      do_refill("sim_dc", 1'b0, 32'h0000_0080);
      step(); dc_miss = 1'b0; #1;
      check_idle("sim_gap", 1'b1);
      do_refill("sim_ic", 1'b1, 32'h0000_01C0);
      step(); ic_miss = 1'b0; #1;
      check_idle("sim_end", 1'b0);

      // Reset in the middle of a refill abandons it without a done pulse.
      step();
      ic_miss = 1'b1; ic_addr = 32'h0000_0300;
      #1;
      step(); #1;
      check_eq("rm_b0_idx", 32'(fill_idx), 32'd0);
      step(); #1;
      check_eq("rm_b1_idx", 32'(fill_idx), 32'd1);
      step(); rst = 1'b1; #1;
      check_eq("rm_rst_icfv", 32'(ic_fill_valid), 32'd0);
      check_eq("rm_rst_done", 32'(ic_done), 32'd0);
      check_eq("rm_rst_cm",   32'(cache_miss), 32'd0);
      step(); #1;
      check_eq("rm_after_req", 32'(mem_req), 32'd0);
      check_eq("rm_after_cm",  32'(cache_miss), 32'd0);
      step(); rst = 1'b0; ic_miss = 1'b0; #1;
      check_idle("rm_rel", 1'b0);
      step(); ic_miss = 1'b1; #1;
      do_refill("rm_re", 1'b1, 32'h0000_0300);
      step(); ic_miss = 1'b0; #1;
      check_idle("rm_end", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Shares the single-word backing-memory port between the instruction-cache refill, the data-cache refill and write-through data stores. It sequences multi-beat line refills, returns fill beats to the requesting cache, and drives the `cache_miss` stall consumed by the hazard unit. It sits between the two L1 caches and the memory model, outside the five pipeline stages.

## Interface
Parameters:
- `LINE_WORDS`, 4: 32-bit words per cache line; power of two, 2..16.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ic_miss` in 1: I-cache refill request; level, held until `ic_done`.
- `ic_addr` in ADDR_W: I-side miss byte address; stable while `ic_miss`.
- `dc_miss` in 1: D-cache refill request; level, held until `dc_done`.
- `dc_addr` in ADDR_W: D-side miss byte address.
- `dc_wr_req` in 1: write-through store request; level, held until `dc_wr_ack`.
- `dc_wr_addr` in ADDR_W: store address, word aligned.
- `dc_wr_data` in 32: store data.
- `ic_fill_valid`, `dc_fill_valid` out 1: fill beat valid for that cache.
- `fill_idx` out $clog2(LINE_WORDS): word index of the current beat within the line.
- `fill_data` out 32: beat data.
- `ic_done`, `dc_done`, `dc_wr_ack` out 1: one-cycle completion pulses.
- `cache_miss` out 1: pipeline stall to the hazard unit.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: word address of the request.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: memory accepts the request; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read data.

## Operation
- FSM states: IDLE, WR, RD_DC, RD_IC.
- In IDLE, the block grants with fixed priority `dc_wr_req` > `dc_miss` > `ic_miss`.
  - Store before refill guarantees that a refill issued after a same-line store reads the new data.
- Grant edge: latch the owner and the address. For refills, base = addr with the low log2(LINE_WORDS*4) bits cleared. Beat counter `cnt` := 0.
- WR: `mem_req`=1, `mem_we`=1, `mem_addr`=`dc_wr_addr`, `mem_wdata`=`dc_wr_data`.
  - On `mem_ack`: `dc_wr_ack`=1 (combinational), next state IDLE.
- RD_x: `mem_req`=1, `mem_we`=0, `mem_addr`=base + 4*cnt.
  - On `mem_ack`: `x_fill_valid`=1, `fill_idx`=cnt, `fill_data`=`mem_rdata` (all combinational); `cnt` increments.
  - If cnt == LINE_WORDS-1 on `mem_ack`: `x_done`=1 the same cycle, next state IDLE.
  - Otherwise `mem_req` stays high and `mem_addr` advances on the next cycle.
- A request not yet granted waits in IDLE until the current transaction finishes. It is then re-arbitrated; the block keeps no queue.
- `cache_miss` = `ic_miss` | `dc_miss` | `dc_wr_req` | (state != IDLE). It is forced to 0 while `rst` is high.
- Outside an ack cycle, fill/done/ack outputs are 0 and `fill_data`/`fill_idx` are 0.
- Address arithmetic is modulo 2^ADDR_W. Beats never cross the line: `cnt` is at most LINE_WORDS-1.

## Timing
- Reset values: state IDLE, `cnt` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, all pulses 0, `cache_miss` 0.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered. The first `mem_req` appears the cycle after the request is seen in IDLE.
- With `mem_ack` tied high, a refill seen at cycle 0 produces beats in cycles 1..LINE_WORDS and `x_done` in cycle LINE_WORDS, and the state is IDLE in cycle LINE_WORDS+1. A store acks in cycle 1.
- The requester drops `x_miss` the cycle after `x_done`. `cache_miss` therefore falls one cycle after `done`, provided no other request is pending.
- A new request is never granted in the done/ack cycle. The minimum gap between transactions is one IDLE cycle.
- Simultaneous `ic_miss` and `dc_miss`: D is served fully, then I. `cache_miss` stays high continuously.
- Reset mid-transaction: the next edge returns to IDLE with `mem_req` 0. No done pulse is issued, and the partial fill is abandoned. Requesters re-request after reset.
- `mem_ack` while `mem_req` is 0 is ignored.

## Structure
- `mem_arb_pkg` holds `arb_state_t` (IDLE, WR, RD_DC, RD_IC), `WORD_BYTES` = 4, and the `line_base` function.
- The block is a single module with no sub-module. The beat counter and FSM are small enough to stay inline.

## Test plan
- **I-side refill:** `ic_miss`=1, `ic_addr`=0x0000_1034, `mem_ack`=1 → `mem_addr` 0x1030, 0x1034, 0x1038, 0x103C in cycles 1-4; `fill_idx` 0..3; `ic_done` in cycle 4; `cache_miss` 1 through cycle 4.
- **Store priority:** `dc_wr_req` (0x200, 0xDEADBEEF) and `ic_miss` (0x100) in the same cycle → write beat first with `mem_we`=1, `dc_wr_ack`; then I refill of 0x100..0x10C.
- **Memory wait states:** `dc_miss` 0x40, `mem_ack` only every 3rd cycle → `mem_addr` holds each beat until acked; 4 `dc_fill_valid` pulses; `dc_done` coincides with the 4th ack.
- **Simultaneous misses:** `dc_miss` and `ic_miss` together → D refill completes, one IDLE cycle, then I refill; `cache_miss` never drops in between.
- **Reset mid-operation:** `rst` after beat 2 of a refill → next cycle `mem_req` 0, no `done`, `cache_miss` 0. After release, a re-asserted `ic_miss` restarts the refill at `fill_idx` 0.
